// File: rtl/i2c_defs.sv
// ============================================================================
// i2c_defs : shared FSM encodings, widths and default address for i2c_target
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package i2c_defs;

    localparam int         BYTE_W       = 8;
    localparam int         PTR_W        = 16;
    localparam logic [6:0] DEV_ADDR_DEF = 7'h3C;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_REGH      = 4'd3,
        ST_REGH_ACK  = 4'd4,
        ST_REGL      = 4'd5,
        ST_REGL_ACK  = 4'd6,
        ST_WDATA     = 4'd7,
        ST_WDATA_ACK = 4'd8,
        ST_RDATA     = 4'd9,
        ST_RDATA_ACK = 4'd10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_line_filter.sv
// ============================================================================
// i2c_line_filter : 2-flop synchronizer, optional glitch filter
//                   (I2C_TGT_GLITCH_FILTER_EN), rise/fall edge outputs
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] r_sync;
    logic       r_prev;
    logic       w_clean;

    // Reset to 1 so an idle (pulled-up) bus produces no edge when reset lifts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], din};
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [CW-1:0] r_cnt;
    logic          r_filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_filt <= 1'b1;
        end else if (r_sync[1] == r_filt) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(FILT_LEN - 1)) begin
            r_filt <= r_sync[1];
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_clean = r_filt;
`else
    assign w_clean = r_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= 1'b1;
        else        r_prev <= w_clean;
    end

    assign level = w_clean;
    assign rise  =  w_clean & ~r_prev;
    assign fall  = ~w_clean &  r_prev;

endmodule

`default_nettype wire

// File: rtl/i2c_target.sv
// ============================================================================
// i2c_target : I2C/SCCB register target, 16-bit pointer, write strobes and
//              read fetch. Option: I2C_TGT_GLITCH_FILTER_EN enables line filter.
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module i2c_target
    import i2c_defs::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
    parameter int         FILT_LEN = 3
) (
    input  logic              meg25,
    input  logic              reset_n,
    input  logic              scl,
    inout  wire               sda,
    output logic              wr_en,
    output logic [PTR_W-1:0]  wr_addr,
    output logic [BYTE_W-1:0] wr_data,
    output logic              rd_req,
    output logic [PTR_W-1:0]  rd_addr,
    input  logic [BYTE_W-1:0] rd_data,
    output logic              busy,
    output logic              nack_seen
);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk(meg25), .rst_n(reset_n), .din(scl),
        .level(w_scl_lvl), .rise(w_scl_rise), .fall(w_scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk(meg25), .rst_n(reset_n), .din(sda),
        .level(w_sda_lvl), .rise(w_sda_rise), .fall(w_sda_fall)
    );

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [6:0]        r_shift;
    logic [6:0]        r_tx;
    logic [PTR_W-1:0]  r_ptr;
    logic              r_oe;
    logic              r_rw;
    logic              r_phase;   // ACK states: 0 = before 9th scl period, 1 = inside it

    logic [7:0] w_byte;
    logic       w_start;
    logic       w_stop;

    assign w_byte  = {r_shift, w_sda_lvl};
    // An sda edge coinciding with an scl edge is not a bus condition
    assign w_start = w_sda_fall & w_scl_lvl & ~w_scl_rise & ~w_scl_fall;
    assign w_stop  = w_sda_rise & w_scl_lvl & ~w_scl_rise & ~w_scl_fall;
    assign sda     = r_oe ? 1'b0 : 1'bz;

    always_ff @(posedge meg25 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_tx      <= '0;
            r_ptr     <= '0;
            r_oe      <= 1'b0;
            r_rw      <= 1'b0;
            r_phase   <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            nack_seen <= 1'b0;
        end else begin
            wr_en  <= 1'b0;
            rd_req <= 1'b0;
            // Byte fetched on the previous rd_req: present its MSB straight away
            if (rd_req) begin
                r_tx <= rd_data[6:0];
                r_oe <= ~rd_data[7];
            end
            if (w_stop) begin
                r_state <= ST_IDLE;
                r_oe    <= 1'b0;
                busy    <= 1'b0;
            end else if (w_start) begin
                r_state   <= ST_ADDR;
                r_cnt     <= '0;
                r_oe      <= 1'b0;
                r_phase   <= 1'b0;
                nack_seen <= 1'b0;
            end else if (w_scl_rise) begin
                if (r_state inside {ST_ADDR, ST_REGH, ST_REGL, ST_WDATA, ST_RDATA}) begin
                    r_shift <= w_byte[6:0];
                    r_cnt   <= r_cnt + 3'd1;
                    r_phase <= 1'b0;
                end
                if (r_cnt == 3'd7) begin
                    case (r_state)
                        ST_ADDR: begin
                            if (w_byte[7:1] == DEV_ADDR) begin
                                r_rw    <= w_byte[0];
                                r_state <= ST_ADDR_ACK;
                                busy    <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                                busy    <= 1'b0;
                            end
                        end
                        ST_REGH: begin
                            r_ptr[15:8] <= w_byte;
                            r_state     <= ST_REGH_ACK;
                        end
                        ST_REGL: begin
                            r_ptr[7:0] <= w_byte;
                            r_state    <= ST_REGL_ACK;
                        end
                        ST_WDATA: begin
                            wr_en   <= 1'b1;
                            wr_addr <= r_ptr;
                            wr_data <= w_byte;
                            r_ptr   <= r_ptr + 16'd1;
                            r_state <= ST_WDATA_ACK;
                        end
                        ST_RDATA: r_state <= ST_RDATA_ACK;
                        default: ;
                    endcase
                end
                if (r_state == ST_RDATA_ACK && r_phase && w_sda_lvl) begin
                    nack_seen <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            end else if (w_scl_fall) begin
                case (r_state)
                    ST_ADDR_ACK, ST_REGH_ACK, ST_REGL_ACK, ST_WDATA_ACK: begin
                        if (!r_phase) begin
                            r_oe    <= 1'b1;
                            r_phase <= 1'b1;
                        end else begin
                            r_oe    <= 1'b0;
                            r_phase <= 1'b0;
                            r_cnt   <= '0;
                            case (r_state)
                                ST_ADDR_ACK: begin
                                    if (r_rw) begin
                                        r_state <= ST_RDATA;
                                        rd_req  <= 1'b1;
                                        rd_addr <= r_ptr;
                                    end else begin
                                        r_state <= ST_REGH;
                                    end
                                end
                                ST_REGH_ACK: r_state <= ST_REGL;
                                default:     r_state <= ST_WDATA;
                            endcase
                        end
                    end
                    ST_RDATA: begin
                        r_tx <= {r_tx[5:0], 1'b0};
                        r_oe <= ~r_tx[6];
                    end
                    ST_RDATA_ACK: begin
                        if (!r_phase) begin
                            r_oe    <= 1'b0;
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            r_cnt   <= '0;
                            r_ptr   <= r_ptr + 16'd1;
                            rd_addr <= r_ptr + 16'd1;
                            rd_req  <= 1'b1;
                            r_state <= ST_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
// ============================================================================
// tb_i2c_target : bit-level I2C master driving i2c_target against a
//                 transaction-level register model
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_target;

    localparam int Q = 10;  // quarter scl period in meg25 cycles

    logic        meg25     = 1'b0;
    logic        reset_n   = 1'b0;
    logic        m_scl     = 1'b1;
    logic        m_sda_low = 1'b0;
    wire         sda;
    logic        wr_en, rd_req, busy, nack_seen;
    logic [15:0] wr_addr, rd_addr;
    logic [7:0]  wr_data, rd_data;

    logic [7:0]  mem [0:65535];
    logic [7:0]  wbuf [0:7];
    logic [23:0] wr_q[$], exp_wr_q[$];
    logic [15:0] rd_q[$], exp_rd_q[$];
    logic [15:0] model_ptr;
    int          n_checks = 0;
    int          n_errors = 0;
    int          dut_low_cnt = 0;
    int          busy_cnt = 0;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);
    assign rd_data = mem[rd_addr];

    always #20 meg25 = ~meg25;

    i2c_target dut (
        .meg25(meg25), .reset_n(reset_n), .scl(m_scl), .sda(sda),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .nack_seen(nack_seen)
    );

    always @(negedge meg25) begin
        if (wr_en)  wr_q.push_back({wr_addr, wr_data});
        if (rd_req) rd_q.push_back(rd_addr);
        if (!m_sda_low && sda === 1'b0) dut_low_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge meg25);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; tick(Q);
        m_scl = 1'b1;     tick(Q);
        m_sda_low = 1'b1; tick(Q);
        m_scl = 1'b0;     tick(Q);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; tick(Q);
        m_scl = 1'b1;     tick(Q);
        m_sda_low = 1'b0; tick(Q);
    endtask

    task automatic write_bit(input logic b, input bit glitch);
        m_sda_low = ~b; tick(Q);
        m_scl = 1'b1;
        if (glitch) begin
            tick(Q);
            m_scl = 1'b0; tick(1);
            m_scl = 1'b1; tick(Q - 1);
        end else begin
            tick(2 * Q);
        end
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; tick(Q);
        m_scl = 1'b1;     tick(Q);
        b = sda;          tick(Q);
        m_scl = 1'b0;     tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input bit glitch, output logic ack_bit);
        for (int i = 7; i >= 0; i--) write_bit(d[i], glitch);
        read_bit(ack_bit);
    endtask

    task automatic read_byte(input bit master_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~master_ack, 1'b0);
    endtask

    task automatic compare_queues(input string tag);
        check_val({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_wr_q.size()));
        for (int i = 0; i < exp_wr_q.size() && i < wr_q.size(); i++)
            check_val($sformatf("%s_wr%0d", tag, i), 32'(wr_q[i]), 32'(exp_wr_q[i]));
        check_val({tag, "_rd_count"}, 32'(rd_q.size()), 32'(exp_rd_q.size()));
        for (int i = 0; i < exp_rd_q.size() && i < rd_q.size(); i++)
            check_val($sformatf("%s_rd%0d", tag, i), 32'(rd_q[i]), 32'(exp_rd_q[i]));
        wr_q.delete(); exp_wr_q.delete(); rd_q.delete(); exp_rd_q.delete();
    endtask

    // Write transaction: pointer then n data bytes taken from wbuf
    task automatic do_write(input logic [15:0] p, input int n, input bit glitch, input string tag);
        logic a;
        bus_start();
        write_byte(8'h78, glitch, a);  check_val({tag, "_ack_addr"}, 32'(a), 0);
        write_byte(p[15:8], 1'b0, a);  check_val({tag, "_ack_ph"}, 32'(a), 0);
        write_byte(p[7:0], 1'b0, a);   check_val({tag, "_ack_pl"}, 32'(a), 0);
        model_ptr = p;
        for (int i = 0; i < n; i++) begin
            exp_wr_q.push_back({model_ptr, wbuf[i]});
            model_ptr = model_ptr + 16'd1;
            write_byte(wbuf[i], 1'b0, a);
            check_val($sformatf("%s_ack_d%0d", tag, i), 32'(a), 0);
        end
        bus_stop();
        tick(Q);
        check_val({tag, "_busy_after_stop"}, 32'(busy), 0);
        compare_queues(tag);
    endtask

    // Read transaction: optional pointer set + repeated START, then n bytes (last NACKed)
    task automatic do_read(input bit set_ptr, input logic [15:0] p, input int n, input string tag);
        logic a;
        logic [7:0] d;
        bus_start();
        if (set_ptr) begin
            write_byte(8'h78, 1'b0, a);   check_val({tag, "_ack_waddr"}, 32'(a), 0);
            write_byte(p[15:8], 1'b0, a); check_val({tag, "_ack_ph"}, 32'(a), 0);
            write_byte(p[7:0], 1'b0, a);  check_val({tag, "_ack_pl"}, 32'(a), 0);
            model_ptr = p;
            bus_start();
        end
        write_byte(8'h79, 1'b0, a);
        check_val({tag, "_ack_raddr"}, 32'(a), 0);
        check_val({tag, "_busy"}, 32'(busy), 1);
        for (int i = 0; i < n; i++) begin
            exp_rd_q.push_back(model_ptr);
            read_byte(i < n - 1, d);
            check_val($sformatf("%s_byte%0d", tag, i), 32'(d), 32'(mem[model_ptr]));
            if (i < n - 1) model_ptr = model_ptr + 16'd1;
        end
        bus_stop();
        tick(Q);
        check_val({tag, "_nack_seen"}, 32'(nack_seen), 1);
        check_val({tag, "_busy_after_stop"}, 32'(busy), 0);
        compare_queues(tag);
    endtask

    initial begin
        #3_600_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        logic [15:0] p;
        int n;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h300A] = 8'h56;
        mem[16'h300B] = 8'h40;

        // Reset state
        tick(5);
        check_val("rst_strobes", {28'd0, wr_en, rd_req, busy, nack_seen}, 0);
        check_val("rst_wr_addr", 32'(wr_addr), 0);
        check_val("rst_wr_data", 32'(wr_data), 0);
        check_val("rst_rd_addr", 32'(rd_addr), 0);
        check_val("rst_sda", 32'(sda), 1);
        reset_n = 1'b1;
        tick(5);

        // Single register write
        wbuf[0] = 8'h82;
        do_write(16'h3008, 1, 1'b0, "wr");

        // Burst across the pointer wrap
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        exp_wr_q.delete();
        do_write(16'hFFFF, 2, 1'b0, "burst");
        check_val("burst_ptr_wrapped", 32'(model_ptr), 32'h0001);

        // Wrong device address
        dut_low_cnt = 0; busy_cnt = 0;
        bus_start();
        write_byte(8'h42, 1'b0, a); check_val("wrong_ack", 32'(a), 1);
        write_byte(8'h30, 1'b0, a);
        write_byte(8'h08, 1'b0, a);
        bus_stop();
        tick(Q);
        check_val("wrong_sda_driven", 32'(dut_low_cnt), 0);
        check_val("wrong_busy_cycles", 32'(busy_cnt), 0);
        compare_queues("wrong");

        // Directed SCCB read: 0x300A, 0x300B
        do_read(1'b1, 16'h300A, 2, "rd");

        // nack_seen clears on next START
        bus_start();
        tick(Q);
        check_val("nack_clear", 32'(nack_seen), 0);
        bus_stop();
        tick(Q);

        // Randomized transactions
        for (int t = 0; t < 14; t++) begin
            p = 16'($urandom);
            if ($urandom_range(0, 3) == 0) p = 16'hFFFF - 16'($urandom_range(0, 1));
            n = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0: begin
                    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
                    do_write(p, n, 1'b0, $sformatf("rnd%0d_w", t));
                end
                1: do_read(1'b1, p, n + 1, $sformatf("rnd%0d_r", t));
                default: do_read(1'b0, p, n + 1, $sformatf("rnd%0d_rc", t));
            endcase
        end

`ifdef I2C_TGT_GLITCH_FILTER_EN
        // Short scl glitch during the address byte must not add a bit
        wbuf[0] = 8'hA7;
        do_write(16'h1234, 1, 1'b1, "glitch");
`endif

        // STOP after 4 data bits: partial byte discarded
        bus_start();
        write_byte(8'h78, 1'b0, a);
        write_byte(8'h12, 1'b0, a);
        write_byte(8'h34, 1'b0, a);
        model_ptr = 16'h1234;
        for (int i = 0; i < 4; i++) write_bit(1'b1, 1'b0);
        bus_stop();
        tick(Q);
        check_val("abort_busy", 32'(busy), 0);
        compare_queues("abort");

        // Reset while the target drives the address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(1'(8'h78 >> i), 1'b0);
        m_sda_low = 1'b0;
        tick(2);
        check_val("rst_mid_ack_driven", 32'(sda), 0);
        check_val("rst_mid_busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check_val("rst_mid_sda_released", 32'(sda), 1);
        check_val("rst_mid_busy_clear", 32'(busy), 0);
        m_scl = 1'b1;
        tick(Q);
        reset_n = 1'b1;
        model_ptr = 16'h0000;
        tick(Q);
        compare_queues("rst_mid");

        // Pointer returns to 0 after reset
        do_read(1'b0, 16'h0000, 1, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
